// File: rtl/stream_xform.sv
// Streaming byte transformer with register bus: per-frame mode selection, mask and optional traffic counters.
// Optional counters are enabled by defining STREAM_XFORM_CNT_EN.
module stream_xform #(
  parameter int unsigned DW       = 8,
  parameter int unsigned RST_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bus_cmd_valid,
  input  logic          bus_op,
  input  logic [15:0]   bus_addr,
  input  logic [15:0]   bus_wr_data,
  output logic [15:0]   bus_rd_data,
  input  logic [DW-1:0] rxd,
  input  logic          rx_dv,
  output logic [DW-1:0] txd,
  output logic          tx_en
);

  localparam int unsigned BW = 16;
  localparam logic [BW-1:0] ADDR_CTRL   = 16'h0009;
  localparam logic [BW-1:0] ADDR_MASK   = 16'h000A;
  localparam logic [BW-1:0] ADDR_STATUS = 16'h000B;
`ifdef STREAM_XFORM_CNT_EN
  localparam logic [BW-1:0] ADDR_BYTE_LO = 16'h000C;
  localparam logic [BW-1:0] ADDR_BYTE_HI = 16'h000D;
  localparam logic [BW-1:0] ADDR_FRAME   = 16'h000E;
`endif

  logic          wr_en;
  logic          rd_en;
  logic [1:0]    ctrl_mode;
  logic [1:0]    active_mode;
  logic [DW-1:0] mask;
  logic          in_frame;
  logic [DW-1:0] xform;
  logic [BW-1:0] rd_val;
  logic          unused_wr;

  assign wr_en     = bus_cmd_valid & bus_op;
  assign rd_en     = bus_cmd_valid & ~bus_op;
  assign unused_wr = ^bus_wr_data;

  // Control registers; active_mode only follows the shadow between frames
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_mode   <= 2'(RST_MODE);
      active_mode <= 2'(RST_MODE);
      mask        <= '0;
      in_frame    <= 1'b0;
    end else begin
      if (!rx_dv) active_mode <= ctrl_mode;
      if (wr_en && bus_addr == ADDR_CTRL) ctrl_mode <= bus_wr_data[1:0];
      if (wr_en && bus_addr == ADDR_MASK) mask <= bus_wr_data[DW-1:0];
      in_frame <= rx_dv;
    end
  end

  always_comb begin
    xform = rxd;
    case (active_mode)
      2'd0:    xform = rxd;
      2'd1:    xform = ~rxd;
      2'd2:    xform = rxd ^ mask;
      default: xform = DW'(rxd + mask);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txd   <= '0;
      tx_en <= 1'b0;
    end else begin
      txd   <= rx_dv ? xform : '0;
      tx_en <= rx_dv;
    end
  end

`ifdef STREAM_XFORM_CNT_EN
  logic [31:0] byte_cnt;
  logic [15:0] frame_cnt;
  logic [15:0] byte_snap;

  // Clearing via BYTE_LO write wins over a same-edge increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      frame_cnt <= '0;
      byte_snap <= '0;
    end else begin
      if (wr_en && bus_addr == ADDR_BYTE_LO) begin
        byte_cnt  <= '0;
        frame_cnt <= '0;
      end else begin
        if (rx_dv) byte_cnt <= byte_cnt + 32'd1;
        if (rx_dv && !in_frame) frame_cnt <= frame_cnt + 16'd1;
      end
      if (rd_en && bus_addr == ADDR_BYTE_LO) byte_snap <= byte_cnt[31:16];
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      ADDR_CTRL:    rd_val = BW'(ctrl_mode);
      ADDR_MASK:    rd_val = BW'(mask);
      ADDR_STATUS:  rd_val = BW'({in_frame, active_mode});
`ifdef STREAM_XFORM_CNT_EN
      ADDR_BYTE_LO: rd_val = byte_cnt[15:0];
      ADDR_BYTE_HI: rd_val = byte_snap;
      ADDR_FRAME:   rd_val = frame_cnt;
`endif
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     bus_rd_data <= '0;
    else if (rd_en) bus_rd_data <= rd_val;
  end

endmodule

// File: tb/tb_stream_xform.sv
// Randomized self-checking bench for stream_xform with a cycle-level behavioural model.
module tb_stream_xform;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_cmd_valid;
  logic        bus_op;
  logic [15:0] bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data;
  logic [7:0]  rxd;
  logic        rx_dv;
  logic [7:0]  txd;
  logic        tx_en;

  logic        b4_cmd;
  logic        b4_op;
  logic [15:0] b4_addr;
  logic [15:0] b4_wd;
  logic [15:0] b4_rd;
  logic [3:0]  rxd4;
  logic        dv4;
  logic [3:0]  txd4;
  logic        ten4;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stream_xform #(.DW(8), .RST_MODE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus_cmd_valid(bus_cmd_valid), .bus_op(bus_op),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .rxd(rxd), .rx_dv(rx_dv), .txd(txd), .tx_en(tx_en)
  );

  stream_xform #(.DW(4), .RST_MODE(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus_cmd_valid(b4_cmd), .bus_op(b4_op),
    .bus_addr(b4_addr), .bus_wr_data(b4_wd), .bus_rd_data(b4_rd),
    .rxd(rxd4), .rx_dv(dv4), .txd(txd4), .tx_en(ten4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state, advanced once per rising edge
  logic [1:0]  m_ctrl, m_active;
  logic [7:0]  m_mask, m_txd;
  logic        m_tx_en, m_prev_dv;
  logic [15:0] m_rd, m_frames, m_snap;
  logic [31:0] m_bytes;

  function automatic logic [7:0] m_f(input logic [1:0] md, input logic [7:0] x, input logic [7:0] k);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, k};
    case (md)
      2'd0:    return x;
      2'd1:    return 8'hFF - x;
      2'd2:    return x ^ k;
      default: return s[7:0];
    endcase
  endfunction

  function automatic logic [15:0] m_reg(input logic [15:0] a);
    case (a)
      16'h0009: return {14'd0, m_ctrl};
      16'h000A: return {8'd0, m_mask};
      16'h000B: return {13'd0, m_prev_dv, m_active};
`ifdef STREAM_XFORM_CNT_EN
      16'h000C: return m_bytes[15:0];
      16'h000D: return m_snap;
      16'h000E: return m_frames;
`endif
      default:  return 16'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ctrl = 2'd0; m_active = 2'd0; m_mask = 8'd0; m_prev_dv = 1'b0;
      m_txd = 8'd0; m_tx_en = 1'b0; m_rd = 16'd0;
      m_bytes = 32'd0; m_frames = 16'd0; m_snap = 16'd0;
    end else begin
      m_tx_en = rx_dv;
      m_txd   = rx_dv ? m_f(m_active, rxd, m_mask) : 8'd0;
      if (bus_cmd_valid && !bus_op) begin
        m_rd = m_reg(bus_addr);
        if (bus_addr == 16'h000C) m_snap = m_bytes[31:16];
      end
      if (bus_cmd_valid && bus_op && bus_addr == 16'h000C) begin
        m_bytes = 32'd0;
        m_frames = 16'd0;
      end else begin
        if (rx_dv) m_bytes = m_bytes + 32'd1;
        if (rx_dv && !m_prev_dv) m_frames = m_frames + 16'd1;
      end
      if (!rx_dv) m_active = m_ctrl;
      if (bus_cmd_valid && bus_op && bus_addr == 16'h0009) m_ctrl = bus_wr_data[1:0];
      if (bus_cmd_valid && bus_op && bus_addr == 16'h000A) m_mask = bus_wr_data[7:0];
      m_prev_dv = rx_dv;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("txd", 32'(txd), 32'(m_txd));
      check("tx_en", 32'(tx_en), 32'(m_tx_en));
      check("bus_rd_data", 32'(bus_rd_data), 32'(m_rd));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus_cmd_valid = 1'b0;
    b4_cmd = 1'b0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    bus_cmd_valid = 1'b1; bus_op = 1'b1; bus_addr = a; bus_wr_data = d;
    step();
  endtask

  task automatic bus_rd(input logic [15:0] a);
    bus_cmd_valid = 1'b1; bus_op = 1'b0; bus_addr = a;
    step();
  endtask

  task automatic b4_access(input logic op, input logic [15:0] a, input logic [15:0] d);
    b4_cmd = 1'b1; b4_op = op; b4_addr = a; b4_wd = d;
    step();
  endtask

  initial begin
    rst_n = 1'b0; bus_cmd_valid = 1'b0; bus_op = 1'b0; bus_addr = '0; bus_wr_data = '0;
    rxd = '0; rx_dv = 1'b0;
    b4_cmd = 1'b0; b4_op = 1'b0; b4_addr = '0; b4_wd = '0; rxd4 = '0; dv4 = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_txd", 32'(txd), 32'h0);
    check("rst_tx_en", 32'(tx_en), 32'h0);
    check("rst_rd", 32'(bus_rd_data), 32'h0);
    check("rst_dut4_tx", 32'({ten4, txd4}), 32'h0);

    // Mode 0 pass-through frame
    bus_rd(16'h000B);
    check("status_rst", 32'(bus_rd_data), 32'h0);
    check("idle_tx_en", 32'(tx_en), 32'h0);
    rx_dv = 1'b1; rxd = 8'h11; step(); check("m0_b0", 32'({tx_en, txd}), 32'h111);
    rxd = 8'h22; step(); check("m0_b1", 32'({tx_en, txd}), 32'h122);
    rxd = 8'h33; step(); check("m0_b2", 32'({tx_en, txd}), 32'h133);
    rx_dv = 1'b0; step(); check("m0_end", 32'({tx_en, txd}), 32'h0);

    // Mode change mid-frame deferred to next frame
    rx_dv = 1'b1; rxd = 8'h0F; step();
    bus_wr(16'h0009, 16'h0001); check("defer_a", 32'(txd), 32'h0F);
    step(); check("defer_b", 32'(txd), 32'h0F);
    rx_dv = 1'b0; step();
    bus_rd(16'h000B); check("status_m1", 32'(bus_rd_data), 32'h1);
    rx_dv = 1'b1; step(); check("m1_inv", 32'(txd), 32'hF0);
    rx_dv = 1'b0;

    // Add with wrap, then XOR
    bus_wr(16'h000A, 16'h00FF);
    bus_wr(16'h0009, 16'h0003);
    step();
    rx_dv = 1'b1; rxd = 8'h02; step(); check("m3_wrap", 32'(txd), 32'h01);
    rx_dv = 1'b0;
    bus_wr(16'h0009, 16'h0002);
    step();
    rx_dv = 1'b1; rxd = 8'hA5; step(); check("m2_xor", 32'(txd), 32'h5A);
    rx_dv = 1'b0; step();

    // CTRL write on an idle edge: old value taken, new one next idle edge
    bus_wr(16'h0009, 16'h0001);
    bus_rd(16'h000B); check("same_edge_old", 32'(bus_rd_data), 32'h2);
    bus_rd(16'h000B); check("same_edge_new", 32'(bus_rd_data), 32'h1);

    // Reset mid-frame
    rx_dv = 1'b1; rxd = 8'h3C; step(); check("pre_rst", 32'(txd), 32'hC3);
    rst_n = 1'b0; step(); check("mid_rst", 32'({tx_en, txd}), 32'h0);
    rst_n = 1'b1; step(); check("post_rst", 32'({tx_en, txd}), 32'h13C);
    rx_dv = 1'b0; step();
    bus_rd(16'h000B); check("status_after_rst", 32'(bus_rd_data), 32'h0);
    bus_rd(16'h0009); check("ctrl_after_rst", 32'(bus_rd_data), 32'h0);

    // Register widths and unmapped addresses
    bus_wr(16'h0009, 16'hFFFF); bus_rd(16'h0009); check("ctrl_w", 32'(bus_rd_data), 32'h3);
    bus_wr(16'h000A, 16'hFFFF); bus_rd(16'h000A); check("mask_w", 32'(bus_rd_data), 32'hFF);
    bus_wr(16'h0020, 16'hFFFF); bus_rd(16'h0020); check("unmapped", 32'(bus_rd_data), 32'h0);
    b4_access(1'b1, 16'h0009, 16'hFFFF); b4_access(1'b0, 16'h0009, 16'h0);
    check("dw4_ctrl", 32'(b4_rd), 32'h3);
    b4_access(1'b1, 16'h000A, 16'hFFFF); b4_access(1'b0, 16'h000A, 16'h0);
    check("dw4_mask", 32'(b4_rd), 32'hF);
    b4_access(1'b0, 16'h0020, 16'h0);
    check("dw4_unmapped", 32'(b4_rd), 32'h0);

    // Counters
    rst_n = 1'b0; step(); rst_n = 1'b1;
`ifdef STREAM_XFORM_CNT_EN
    rx_dv = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      rxd = 8'(i); step();
    end
    rx_dv = 1'b0; step();
    rx_dv = 1'b1; step(); step();
    rx_dv = 1'b0; step();
    bus_rd(16'h000C); check("byte_lo", 32'(bus_rd_data), 32'h0002);
    bus_rd(16'h000D); check("byte_hi", 32'(bus_rd_data), 32'h0001);
    bus_rd(16'h000E); check("frame_cnt", 32'(bus_rd_data), 32'h0002);
    rx_dv = 1'b1; step();
    bus_wr(16'h000C, 16'h0000);
    bus_rd(16'h000C); check("cnt_clear", 32'(bus_rd_data), 32'h0);
    rx_dv = 1'b0; step();
`else
    rx_dv = 1'b1; step(); step();
    rx_dv = 1'b0; step();
    bus_rd(16'h000C); check("no_cnt_lo", 32'(bus_rd_data), 32'h0);
    bus_rd(16'h000D); check("no_cnt_hi", 32'(bus_rd_data), 32'h0);
    bus_rd(16'h000E); check("no_cnt_frame", 32'(bus_rd_data), 32'h0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      if ($urandom_range(0, 5) == 0) rx_dv = ~rx_dv;
      rxd = 8'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 9));
        bus_cmd_valid = 1'b1;
        bus_op = 1'($urandom_range(0, 1));
        bus_wr_data = 16'($urandom);
        if (r < 8)       bus_addr = 16'(9 + r);
        else if (r == 8) bus_addr = 16'h0020;
        else             bus_addr = 16'($urandom);
      end
      step();
    end
    rst_n = 1'b1; rx_dv = 1'b0; step(); step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
